run_pattern_gen: RTL
====================

// Module: run_pattern_gen
// PURPOSE
//   Serial run-length pattern generator. Accepts (bit value, run length) commands over a
//   valid/ready handshake and drives them as a 1-bit-per-clock serial stream on out.
//   Produces stimulus streams for the lab's serial run-detector FSMs, e.g. runs of 3+ ones
//   or 3+ zeros. A one-entry pending register allows gapless back-to-back runs.
// PARAMETERS
//   LEN_W     4    width of cmd_len; maximum run length 2**LEN_W-1
//   IDLE_BIT  1'b0 level driven on out while no run is active
// PORTS
//   CLK        in   1      clock; all state updates on rising edge
//   nRESET     in   1      asynchronous, active-low reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      generator can accept a command this cycle
//   cmd_bit    in   1      bit value of the run
//   cmd_len    in   LEN_W  run length in clocks; 0 = null command
//   out        out  1      serial data bit
//   out_valid  out  1      out carries a run bit this cycle
//   run_done   out  1      high during the last bit of each run
//   busy       out  1      run active or command pending
// BEHAVIOUR
//   Reset (async, nRESET=0): state=IDLE, pend_valid=0, cnt=0, cur_bit=IDLE_BIT.
//     Outputs: out=IDLE_BIT, out_valid=0, run_done=0, busy=0, cmd_ready=1.
//     A reset mid-run aborts the run immediately and drops any pending command.
//   Handshake: a command is accepted on an edge where cmd_valid && cmd_ready.
//     cmd_ready = !pend_valid. It is derived from registers only and never depends on cmd_valid.
//     An accepted command is written to the pending register (pend_bit, pend_len, pend_valid=1).
//   FSM states: IDLE, SEND. Registers: cur_bit, cnt[LEN_W-1:0].
//     Load event on an edge: pend_valid=1 and (state==IDLE or (state==SEND and cnt==1)).
//       pend_len!=0: cur_bit<=pend_bit, cnt<=pend_len, state<=SEND, pend_valid<=0.
//       pend_len==0: pend_valid<=0 and nothing is loaded. Treat it as no command pending.
//         A SEND run with cnt==1 then goes to IDLE.
//     SEND with cnt>1: cnt<=cnt-1.
//     SEND with cnt==1 and no valid load: state<=IDLE, cnt<=0.
//     Accept and load on the same edge: the load uses the old pending contents and the
//       accepted command lands in the pending register. Because cmd_ready=!pend_valid, this
//       only happens when the pending register is empty, so it cannot occur.
//   Outputs are functions of registered state only:
//     out       = (state==SEND) ? cur_bit : IDLE_BIT
//     out_valid = (state==SEND)
//     run_done  = (state==SEND && cnt==1)
//     busy      = (state==SEND) || pend_valid
//   Latency: command accepted at edge k. From IDLE, its first bit is visible after edge k+1
//     and it holds for exactly cmd_len cycles.
//   Throughput: consecutive runs are gapless when each run (other than the first) is queued
//     before the previous run's last cycle. This is guaranteed for runs with len>=2 while
//     cmd_valid stays high. len=1 runs may leave 1-cycle gaps (out_valid=0).
//   Consecutive runs with equal cmd_bit merge on the wire. run_done still pulses once per run.
//   cmd_len max = 2**LEN_W-1. The count never wraps; cnt is loaded only on a load event.
// TESTING
//   1 Assert nRESET=0 mid-stream -> out=0, out_valid=0, run_done=0, busy=0, cmd_ready=1
//     immediately, without waiting for CLK.
//   2 Accept (bit=1, len=3) at edge k from IDLE -> out_valid=1, out=1 after edges k+1..k+3;
//     run_done=1 only after k+3; out_valid=0 after k+4.
//   3 cmd_valid held with (1,3) then (0,4) -> contiguous stream 1,1,1,0,0,0,0; out_valid never
//     drops; exactly 2 run_done pulses.
//   4 Accept (0, len=0) -> out_valid and run_done stay 0; busy high 1 cycle; cmd_ready=1 next cycle.
//   5 A=(1,5) running, B=(0,2) pending, C=(1,3) presented -> cmd_ready=0 until B loads;
//     C is held by the source and is output intact after B: 11111 00 111.
//   6 Reset asserted on the 2nd bit of a len=6 run with a command pending -> after release,
//     out_valid stays 0 and busy stays 0 until a new command is accepted.

Source files
------------

// File: rtl/run_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// run_pattern_gen_if
//   Command channel of the serial run-length pattern generator: one
//   (bit value, run length) command per valid/ready handshake.
//
//   cmd_valid  source -> generator  command present
//   cmd_ready  generator -> source  generator can take a command this cycle
//   cmd_bit    source -> generator  bit value of the run
//   cmd_len    source -> generator  run length in clocks, 0 = null command
//
//   Modports: master = command source, slave = generator.
// ---------------------------------------------------------------------------
interface run_pattern_gen_if #(
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_bit;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_bit,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_bit,
    input  cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/run_pattern_gen.sv
// ---------------------------------------------------------------------------
// run_pattern_gen
//   Serial run-length pattern generator. Commands (bit, len) arrive over the
//   cmd interface and are played out one bit per clock on out. A one-entry
//   pending register lets the next run be queued while the current one plays,
//   so runs of length >= 2 follow each other without gaps.
//
//   Parameters
//     LEN_W     width of cmd_len, longest run is 2**LEN_W-1 clocks
//     IDLE_BIT  level on out while no run is active
//
//   Ports
//     CLK        in   clock, rising edge
//     nRESET     in   asynchronous active-low reset
//     cmd        slave modport of run_pattern_gen_if (valid/ready/bit/len)
//     out        out  serial data bit
//     out_valid  out  out carries a run bit this cycle
//     run_done   out  high during the last bit of each run
//     busy       out  run active or command pending
// ---------------------------------------------------------------------------
module run_pattern_gen #(
  parameter int   LEN_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic               CLK,
  input  logic               nRESET,
  run_pattern_gen_if.slave   cmd,
  output logic               out,
  output logic               out_valid,
  output logic               run_done,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  logic             cur_bit;
  logic [LEN_W-1:0] cnt;

  logic             pend_valid;
  logic             pend_bit;
  logic [LEN_W-1:0] pend_len;

  logic             accept;
  logic             last_bit;
  logic             load_slot;

  // Ready comes from the pending flag alone, so a source may legally wait for
  // ready before raising valid without creating a combinational loop.
  assign cmd.cmd_ready = !pend_valid;
  assign accept        = cmd.cmd_valid && !pend_valid;

  assign last_bit  = (state == SEND) && (cnt == LEN_W'(1));
  // The pending command may move into the shift counter when nothing is
  // playing, or during the final bit of the current run (gapless hand-off).
  assign load_slot = pend_valid && ((state == IDLE) || last_bit);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order in the block.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state      <= IDLE;
      cur_bit    <= IDLE_BIT;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_bit   <= 1'b0;
      pend_len   <= '0;
    end else begin
      // Run counter / FSM. A zero-length pending command is discarded
      // without loading, so it falls through to the normal countdown.
      if (load_slot && (pend_len != '0)) begin
        cur_bit <= pend_bit;
        cnt     <= pend_len;
        state   <= SEND;
      end else if (state == SEND) begin
        if (last_bit) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - LEN_W'(1);
        end
      end

      // Pending register. Accept needs pend_valid=0 and a load needs
      // pend_valid=1, so the two never coincide on one edge.
      if (accept) begin
        pend_valid <= 1'b1;
        pend_bit   <= cmd.cmd_bit;
        pend_len   <= cmd.cmd_len;
      end else if (load_slot) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign out       = (state == SEND) ? cur_bit : IDLE_BIT;
  assign out_valid = (state == SEND);
  assign run_done  = last_bit;
  assign busy      = (state == SEND) || pend_valid;

endmodule
